heart_bar_ctrl: RTL and testbench

//  Health controller for the HUD heart row. Holds player HP in half-heart units and applies damage/heal pulses.

---
 rtl/heart_bar_ctrl.sv | 141 ++++++++++++++
 tb/tb_heart_bar_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/heart_bar_ctrl.sv
// Heart-row health controller: holds HP in half-heart units, applies
// damage/heal pulses, runs a post-hit invincibility window with frame-timed
// blinking, and decodes per-slot visible/divided flags for the heart sprites.
module heart_bar_ctrl #(
    parameter  int NUM_HEARTS   = 3,
    parameter  int INV_FRAMES   = 60,
    parameter  int BLINK_FRAMES = 8,
    localparam int HP_W         = $clog2(2*NUM_HEARTS+1)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  new_frame_in,
    input  logic                  damage_in,
    input  logic                  heal_in,
    input  logic                  restart_in,
    output logic [HP_W-1:0]       hp_out,
    output logic [NUM_HEARTS-1:0] heart_visible_out,
    output logic [NUM_HEARTS-1:0] heart_divided_out,
    output logic                  invincible_out,
    output logic                  dead_out
);

    localparam int INV_W   = $clog2(INV_FRAMES+1);
    localparam int BLINK_W = $clog2(BLINK_FRAMES+1);
    localparam logic [HP_W-1:0]    HP_MAX    = HP_W'(2*NUM_HEARTS);
    localparam logic [INV_W-1:0]   INV_LOAD  = INV_W'(INV_FRAMES);
    localparam logic [BLINK_W-1:0] BLINK_TOP = BLINK_W'(BLINK_FRAMES);

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        HIT   = 2'd1,
        DEAD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [HP_W-1:0]    hp_q, hp_d;
    logic [INV_W-1:0]   inv_cnt_q, inv_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic [BLINK_W-1:0] blink_inc;

    // State and datapath registers; reset gives full health, ALIVE, slots shown.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ALIVE;
            hp_q        <= HP_MAX;
            inv_cnt_q   <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            hp_q        <= hp_d;
            inv_cnt_q   <= inv_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    // Next state: restart overrides everything, then damage/heal, then frame timing.
    always_comb begin
        state_d     = state_q;
        hp_d        = hp_q;
        inv_cnt_d   = inv_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        blink_inc   = blink_cnt_q + BLINK_W'(1);
        if (restart_in) begin
            state_d     = ALIVE;
            hp_d        = HP_MAX;
            inv_cnt_d   = '0;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else begin
            case (state_q)
                ALIVE: begin
                    if (damage_in && !heal_in) begin
                        if (hp_q != '0) begin
                            hp_d = hp_q - HP_W'(1);
                        end
                        if (hp_q <= HP_W'(1)) begin
                            state_d = DEAD;
                        end else begin
                            // Entry frame is not counted: the frame pulse is ignored here.
                            state_d     = HIT;
                            inv_cnt_d   = INV_LOAD;
                            blink_cnt_d = '0;
                            blink_on_d  = 1'b0;
                        end
                    end else if (heal_in && !damage_in && hp_q != HP_MAX) begin
                        hp_d = hp_q + HP_W'(1);
                    end
                end
                HIT: begin
                    if (heal_in && hp_q != HP_MAX) begin
                        hp_d = hp_q + HP_W'(1);
                    end
                    if (new_frame_in) begin
                        if (blink_inc == BLINK_TOP) begin
                            blink_cnt_d = '0;
                            blink_on_d  = ~blink_on_q;
                        end else begin
                            blink_cnt_d = blink_inc;
                        end
                        if (inv_cnt_q <= INV_W'(1)) begin
                            state_d     = ALIVE;
                            inv_cnt_d   = '0;
                            blink_cnt_d = '0;
                            blink_on_d  = 1'b1;
                        end else begin
                            inv_cnt_d = inv_cnt_q - INV_W'(1);
                        end
                    end
                end
                DEAD: begin
                    hp_d = '0;
                end
                default: begin
                    state_d = ALIVE;
                end
            endcase
        end
    end

    // Output decode: per-slot full/half from registered HP, gated by blink in HIT.
    always_comb begin
        hp_out            = hp_q;
        invincible_out    = (state_q == HIT);
        dead_out          = (state_q == DEAD);
        heart_visible_out = '0;
        heart_divided_out = '0;
        for (int i = 0; i < NUM_HEARTS; i++) begin
            logic full_s, half_s, vis_s;
            full_s = (hp_q >= HP_W'(2*i+2));
            half_s = (hp_q == HP_W'(2*i+1));
            vis_s  = (full_s || half_s) && ((state_q != HIT) || blink_on_q);
            heart_visible_out[i] = vis_s;
            heart_divided_out[i] = half_s && vis_s;
        end
    end

endmodule

// File: tb/tb_heart_bar_ctrl.sv
// Bench for heart_bar_ctrl: directed scenarios plus random event traffic,
// checked every cycle against a frame-counting reference model.
module tb_heart_bar_ctrl;

    localparam int NH    = 3;
    localparam int INV   = 4;
    localparam int BLINK = 2;
    localparam int HPW   = 3;
    localparam int MAXHP = 2*NH;

    logic           clk_in = 1'b0;
    logic           rst_in = 1'b1;
    logic           new_frame_in = 1'b0;
    logic           damage_in = 1'b0;
    logic           heal_in = 1'b0;
    logic           restart_in = 1'b0;
    logic [HPW-1:0] hp_out;
    logic [NH-1:0]  heart_visible_out;
    logic [NH-1:0]  heart_divided_out;
    logic           invincible_out;
    logic           dead_out;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode 0=alive 1=hit 2=dead; elapsed = frames since hit.
    int m_hp      = MAXHP;
    int m_mode    = 0;
    int m_elapsed = 0;

    heart_bar_ctrl #(.NUM_HEARTS(NH), .INV_FRAMES(INV), .BLINK_FRAMES(BLINK)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .new_frame_in      (new_frame_in),
        .damage_in         (damage_in),
        .heal_in           (heal_in),
        .restart_in        (restart_in),
        .hp_out            (hp_out),
        .heart_visible_out (heart_visible_out),
        .heart_divided_out (heart_divided_out),
        .invincible_out    (invincible_out),
        .dead_out          (dead_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic model_reset();
        m_hp = MAXHP; m_mode = 0; m_elapsed = 0;
    endtask

    task automatic model_step(input bit r, input bit d, input bit h, input bit f);
        if (r) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (d && !h) begin
                if (m_hp > 0) m_hp = m_hp - 1;
                if (m_hp == 0) m_mode = 2;
                else begin m_mode = 1; m_elapsed = 0; end
            end else if (h && !d) begin
                m_hp = (m_hp + 1 > MAXHP) ? MAXHP : m_hp + 1;
            end
        end else if (m_mode == 1) begin
            if (h) m_hp = (m_hp + 1 > MAXHP) ? MAXHP : m_hp + 1;
            if (f) begin
                m_elapsed++;
                if (m_elapsed >= INV) m_mode = 0;
            end
        end
    endtask

    function automatic logic [NH-1:0] exp_vis();
        logic [NH-1:0] v;
        bit shown;
        shown = (m_mode != 1) || (((m_elapsed / BLINK) % 2) == 1);
        for (int i = 0; i < NH; i++) v[i] = (m_hp > 2*i) && shown;
        return v;
    endfunction

    function automatic logic [NH-1:0] exp_div();
        logic [NH-1:0] dv;
        logic [NH-1:0] v;
        v  = exp_vis();
        dv = '0;
        for (int i = 0; i < NH; i++) dv[i] = (m_hp % 2 == 1) && (i == m_hp / 2) && v[i];
        return dv;
    endfunction

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check_val({tag, ".hp"},   int'(hp_out), m_hp);
        check_val({tag, ".vis"},  int'(heart_visible_out), int'(exp_vis()));
        check_val({tag, ".div"},  int'(heart_divided_out), int'(exp_div()));
        check_val({tag, ".inv"},  int'(invincible_out), (m_mode == 1) ? 1 : 0);
        check_val({tag, ".dead"}, int'(dead_out), (m_mode == 2) ? 1 : 0);
    endtask

    // Apply one cycle of inputs, clock it, update the model, check #1 after the edge.
    task automatic step(input bit r, input bit d, input bit h, input bit f, input string tag);
        restart_in = r; damage_in = d; heal_in = h; new_frame_in = f;
        @(posedge clk_in);
        model_step(r, d, h, f);
        #1;
        restart_in = 1'b0; damage_in = 1'b0; heal_in = 1'b0; new_frame_in = 1'b0;
        check_model(tag);
    endtask

    initial begin
        bit r, d, h, f;
        // 1. reset values
        rst_in = 1'b1;
        #12;
        check_val("rst.hp", int'(hp_out), 6);
        check_val("rst.vis", int'(heart_visible_out), 7);
        check_val("rst.div", int'(heart_divided_out), 0);
        check_val("rst.inv", int'(invincible_out), 0);
        check_val("rst.dead", int'(dead_out), 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();

        // 2. hit and blink timing
        step(0, 1, 0, 0, "hit");
        check_val("hit.hp", int'(hp_out), 5);
        check_val("hit.vis", int'(heart_visible_out), 0);
        check_val("hit.inv", int'(invincible_out), 1);
        step(0, 0, 0, 1, "fr1");
        step(0, 0, 0, 1, "fr2");
        check_val("fr2.vis", int'(heart_visible_out), 7);
        check_val("fr2.div", int'(heart_divided_out), 4);
        step(0, 0, 0, 1, "fr3");
        step(0, 0, 0, 1, "fr4");
        check_val("fr4.inv", int'(invincible_out), 0);

        // 3. damage ignored in HIT, heal applies
        step(0, 0, 1, 0, "heal6");
        step(0, 1, 0, 1, "hit2");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "hitdmg");
        check_val("hitdmg.hp", int'(hp_out), 5);
        step(0, 0, 1, 0, "hitheal");
        check_val("hitheal.hp", int'(hp_out), 6);
        for (int i = 0; i < INV; i++) step(0, 0, 0, 1, "exit");

        // 4. cancel and saturation
        step(0, 1, 1, 0, "cancel");
        check_val("cancel.inv", int'(invincible_out), 0);
        step(0, 0, 1, 0, "sat");
        check_val("sat.hp", int'(hp_out), 6);

        // 5. drain to death, inputs ignored, restart
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 0, "drain");
            if (m_mode == 1)
                for (int i = 0; i < INV; i++) step(0, 0, 0, 1, "drainfr");
        end
        check_val("dead.flag", int'(dead_out), 1);
        check_val("dead.vis", int'(heart_visible_out), 0);
        step(0, 0, 1, 1, "deadheal");
        step(0, 1, 0, 0, "deaddmg");
        check_val("deadign.hp", int'(hp_out), 0);
        step(1, 1, 1, 1, "restart");
        check_val("restart.vis", int'(heart_visible_out), 7);

        // 6. asynchronous reset mid-HIT
        step(0, 1, 0, 0, "prearst");
        step(0, 0, 0, 1, "prearst2");
        #2;
        rst_in = 1'b1;
        #1;
        check_val("arst.hp", int'(hp_out), 6);
        check_val("arst.vis", int'(heart_visible_out), 7);
        check_val("arst.inv", int'(invincible_out), 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 39) == 0);
            d = ($urandom_range(0, 5) == 0);
            h = ($urandom_range(0, 7) == 0);
            f = ($urandom_range(0, 2) == 0);
            step(r, d, h, f, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
